// File: rtl/segment_pkg.sv
// Shared types and constants for the multiplexed 7-segment display controller.
// The font is packed 7 bits per glyph, glyph 0 in the low bits.
package segment_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        COMMIT
    } state_e;

    localparam int unsigned SEG_A  = 0;
    localparam int unsigned SEG_B  = 1;
    localparam int unsigned SEG_C  = 2;
    localparam int unsigned SEG_D  = 3;
    localparam int unsigned SEG_E  = 4;
    localparam int unsigned SEG_F  = 5;
    localparam int unsigned SEG_G  = 6;
    localparam int unsigned SEG_DP = 7;

    localparam int unsigned GLYPH_W = 7;

    // Glyph order, high to low: F E d C b A 9 8 7 6 5 4 3 2 1 0
    localparam logic [16*GLYPH_W-1:0] FONT = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [GLYPH_W-1:0] font_glyph(input logic [3:0] nibble);
        return FONT[{3'b000, nibble} * 7'd7 +: GLYPH_W];
    endfunction

endpackage

// File: rtl/seg7_encoder.sv
// Combinational hex-to-7-segment encoder with blanking and decimal point.
// The decimal point survives blanking so a blanked digit can still show its dp.
module seg7_encoder
    import segment_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       blank_i,
    input  logic       dp_i,
    output logic [7:0] pattern_o
);

    always_comb begin
        pattern_o = '0;
        if (!blank_i) begin
            pattern_o[SEG_G:SEG_A] = font_glyph(nibble_i);
        end
        pattern_o[SEG_DP] = dp_i;
    end

endmodule

// File: rtl/segment_scan_controller.sv
// Scan timebase, PWM brightness gate and value-to-digit-array sequencer for a
// multiplexed 7-segment display. New values become visible only on a scan boundary.
module segment_scan_controller
    import segment_pkg::*;
#(
    parameter int unsigned NUMBER_OF_DIGITS   = 4,
    parameter int unsigned NUMBER_OF_SEGMENTS = 8,
    parameter int unsigned SCAN_DIVIDER       = 1000,
    parameter int unsigned BRIGHTNESS_BITS    = 4
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          value_valid,
    output logic                          value_ready,
    input  logic [4*NUMBER_OF_DIGITS-1:0] value_data,
    input  logic [NUMBER_OF_DIGITS-1:0]   dp_mask,
    input  logic                          blank_leading_zeros,
    input  logic [BRIGHTNESS_BITS-1:0]    brightness,
    output logic                          next_segment,
    output logic [NUMBER_OF_SEGMENTS-1:0] digits [0:NUMBER_OF_DIGITS-1],
    output logic                          display_enable
);

    localparam int unsigned D     = NUMBER_OF_DIGITS;
    localparam int unsigned IDX_W = $clog2(NUMBER_OF_DIGITS);
    localparam int unsigned PS_W  = $clog2(SCAN_DIVIDER);
    localparam logic [PS_W-1:0]  PS_LAST   = PS_W'(SCAN_DIVIDER - 1);
    localparam logic [IDX_W-1:0] IDX_FIRST = IDX_W'(NUMBER_OF_DIGITS - 1);

    // Control state
    state_e                       state_q, state_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic                         leading_q, leading_d;
    logic                         value_ready_q, value_ready_d;
    logic [PS_W-1:0]              prescaler_q, prescaler_d;
    logic                         next_segment_q, next_segment_d;
    logic [BRIGHTNESS_BITS-1:0]   pwm_q, pwm_d;
    logic                         display_enable_q, display_enable_d;
    logic [NUMBER_OF_SEGMENTS-1:0] digits_q [0:D-1];

    // Captured value and shadow array
    logic [4*D-1:0]               value_q;
    logic [D-1:0]                 dp_q;
    logic                         blank_q;
    logic [NUMBER_OF_SEGMENTS-1:0] shadow_q [0:D-1];

    logic                         scan_wrap;
    logic                         accept;
    logic                         commit;
    logic [3:0]                   nibble_sel;
    logic                         dp_sel;
    logic                         blank_digit;
    logic [7:0]                   enc_pattern;

    assign scan_wrap = (prescaler_q == PS_LAST);

    always_comb begin
        nibble_sel = '0;
        dp_sel     = 1'b0;
        for (int i = 0; i < int'(D); i++) begin
            if (idx_q == IDX_W'(i)) begin
                nibble_sel = value_q[i*4 +: 4];
                dp_sel     = dp_q[i];
            end
        end
    end

    // Digit 0 always shows, so a zero value still displays a single "0".
    assign blank_digit = blank_q && leading_q && (nibble_sel == 4'h0) && (idx_q != '0);

    seg7_encoder u_encoder (
        .nibble_i  (nibble_sel),
        .blank_i   (blank_digit),
        .dp_i      (dp_sel),
        .pattern_o (enc_pattern)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        leading_d = leading_q;
        accept    = 1'b0;
        commit    = 1'b0;

        case (state_q)
            IDLE: begin
                if (value_valid && value_ready_q) begin
                    accept    = 1'b1;
                    idx_d     = IDX_FIRST;
                    leading_d = 1'b1;
                    state_d   = CONVERT;
                end
            end
            CONVERT: begin
                leading_d = blank_digit;
                idx_d     = idx_q - 1'b1;
                if (idx_q == '0) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                // Aligning with the scan wrap lets the scanner's next sample see the whole new array.
                if (scan_wrap) begin
                    commit  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        value_ready_d    = (state_d == IDLE);
        prescaler_d      = scan_wrap ? '0 : prescaler_q + 1'b1;
        next_segment_d   = scan_wrap;
        pwm_d            = pwm_q + 1'b1;
        display_enable_d = (pwm_q < brightness);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= IDLE;
            idx_q            <= '0;
            leading_q        <= 1'b0;
            value_ready_q    <= 1'b0;
            prescaler_q      <= '0;
            next_segment_q   <= 1'b0;
            pwm_q            <= '0;
            display_enable_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            idx_q            <= idx_d;
            leading_q        <= leading_d;
            value_ready_q    <= value_ready_d;
            prescaler_q      <= prescaler_d;
            next_segment_q   <= next_segment_d;
            pwm_q            <= pwm_d;
            display_enable_q <= display_enable_d;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(D); i++) begin
                digits_q[i] <= '0;
            end
        end else if (commit) begin
            for (int i = 0; i < int'(D); i++) begin
                digits_q[i] <= shadow_q[i];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            value_q <= value_data;
            dp_q    <= dp_mask;
            blank_q <= blank_leading_zeros;
        end
        if (state_q == CONVERT) begin
            for (int i = 0; i < int'(D); i++) begin
                if (idx_q == IDX_W'(i)) begin
                    shadow_q[i] <= enc_pattern;
                end
            end
        end
    end

    assign value_ready    = value_ready_q;
    assign next_segment   = next_segment_q;
    assign display_enable = display_enable_q;
    assign digits         = digits_q;

endmodule

// File: tb/tb_segment_scan_controller.sv
// Directed bench for segment_scan_controller with D=4, SCAN_DIVIDER=8, B=4.
module tb_segment_scan_controller;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        value_valid;
    logic        value_ready;
    logic [15:0] value_data;
    logic [3:0]  dp_mask;
    logic        blank_leading_zeros;
    logic [3:0]  brightness;
    logic        next_segment;
    logic [7:0]  digits [0:3];
    logic        display_enable;

    int errors = 0;
    int checks = 0;

    segment_scan_controller #(
        .NUMBER_OF_DIGITS   (4),
        .NUMBER_OF_SEGMENTS (8),
        .SCAN_DIVIDER       (8),
        .BRIGHTNESS_BITS    (4)
    ) dut (
        .clock               (clock),
        .reset_n             (reset_n),
        .value_valid         (value_valid),
        .value_ready         (value_ready),
        .value_data          (value_data),
        .dp_mask             (dp_mask),
        .blank_leading_zeros (blank_leading_zeros),
        .brightness          (brightness),
        .next_segment        (next_segment),
        .digits              (digits),
        .display_enable      (display_enable)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pack_digits();
        return {digits[3], digits[2], digits[1], digits[0]};
    endfunction

    // Offer one value, then watch for the commit and compare the whole array.
    task automatic write_value(input string tag, input logic [15:0] data, input logic [3:0] dp,
                               input logic blk, input logic [31:0] exp,
                               input bit hold, input logic [15:0] hold_data);
        int          waited;
        int          n;
        bit          seen;
        logic [31:0] old;
        waited = 0;
        @(negedge clock);
        while (!value_ready && waited < 40) begin
            @(negedge clock);
            waited++;
        end
        check({tag, "_ready"}, 32'(value_ready), 32'd1);
        value_valid         = 1'b1;
        value_data          = data;
        dp_mask             = dp;
        blank_leading_zeros = blk;
        old                 = pack_digits();
        @(negedge clock);
        check({tag, "_ready_drop"}, 32'(value_ready), 32'd0);
        if (hold) begin
            value_data          = hold_data;
            dp_mask             = 4'hF;
            blank_leading_zeros = 1'b1;
        end else begin
            value_valid = 1'b0;
        end
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(posedge clock);
            #1;
            n++;
            if (pack_digits() != old) seen = 1'b1;
        end
        check({tag, "_commit_seen"}, 32'(seen), 32'd1);
        check({tag, "_nseg_at_commit"}, 32'(next_segment), 32'd1);
        check({tag, "_latency_in_range"}, 32'(n >= 5 && n <= 12), 32'd1);
        check({tag, "_digits"}, pack_digits(), exp);
        check({tag, "_ready_back"}, 32'(value_ready), 32'd1);
    endtask

    task automatic pwm_window(input string tag, input logic [3:0] level);
        int high;
        @(negedge clock);
        brightness = level;
        repeat (2) @(posedge clock);
        high = 0;
        for (int k = 0; k < 16; k++) begin
            @(posedge clock);
            #1;
            if (display_enable) high++;
        end
        check(tag, 32'(high), 32'(level));
    endtask

    initial begin
        reset_n             = 1'b0;
        value_valid         = 1'b0;
        value_data          = '0;
        dp_mask             = '0;
        blank_leading_zeros = 1'b0;
        brightness          = '0;

        #12;
        check("rst_digits", pack_digits(), 32'h0);
        check("rst_ready", 32'(value_ready), 32'd0);
        check("rst_nseg", 32'(next_segment), 32'd0);
        check("rst_en", 32'(display_enable), 32'd0);

        // Release between edges; first strobe lands after the 8th edge.
        @(negedge clock);
        reset_n = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            @(posedge clock);
            #1;
            check("nseg_period", 32'(next_segment), 32'((k % 8) == 0));
            if (k == 1) begin
                check("ready_after_release", 32'(value_ready), 32'd1);
                check("digits_blank_after_release", pack_digits(), 32'h0);
            end
        end

        write_value("w1234", 16'h1234, 4'b0000, 1'b0, 32'h065B4F66, 1'b0, 16'h0);
        write_value("w0005", 16'h0005, 4'b0100, 1'b1, 32'h0080006D, 1'b0, 16'h0);
        write_value("w0000", 16'h0000, 4'b0000, 1'b1, 32'h0000003F, 1'b0, 16'h0);

        // Held valid with changing data: first value commits, second only after ready returns.
        write_value("hold_first", 16'h1234, 4'b0000, 1'b0, 32'h065B4F66, 1'b1, 16'hABCD);
        write_value("hold_second", 16'hABCD, 4'b0000, 1'b0, 32'h777C395E, 1'b0, 16'h0);

        pwm_window("pwm_0", 4'd0);
        pwm_window("pwm_5", 4'd5);
        pwm_window("pwm_15", 4'd15);

        // Asynchronous reset in the middle of CONVERT.
        @(negedge clock);
        value_valid = 1'b1;
        value_data  = 16'h8888;
        dp_mask     = 4'hF;
        @(negedge clock);
        value_valid = 1'b0;
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_digits", pack_digits(), 32'h0);
        check("midrst_ready", 32'(value_ready), 32'd0);
        check("midrst_nseg", 32'(next_segment), 32'd0);
        check("midrst_en", 32'(display_enable), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (30) @(posedge clock);
        #1;
        check("postrst_digits", pack_digits(), 32'h0);
        check("postrst_ready", 32'(value_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
